// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the multi-channel arbitrated memory controller.
package mem_arb_pkg;

    // Request priority: a wider value beats a narrower one, ties go round-robin.
    localparam int PRI_W = 2;
    typedef logic [PRI_W-1:0] pri_t;

    // Supported read latencies, in cycles from read handshake to rvalid.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 2;

    // Any latency outside the supported window is pulled to the nearest legal value.
    function automatic int clamp_rd_lat(input int lat);
        if (lat <= RD_LAT_MIN) begin
            return RD_LAT_MIN;
        end
        if (lat >= RD_LAT_MAX) begin
            return RD_LAT_MAX;
        end
        return lat;
    endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Priority-then-round-robin picker: among the requesters carrying the highest
// priority, grants the first one at or after ptr, wrapping modulo NUM_CH.
module mem_arb_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  pri_t [NUM_CH-1:0]         pri,
    input  logic [$clog2(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]         gnt,
    output logic [$clog2(NUM_CH)-1:0] winner,
    output logic                      any
);

    localparam int IW = $clog2(NUM_CH);

    pri_t                  max_pri;
    logic [NUM_CH-1:0]     cand;
    logic [2*NUM_CH-1:0]   cand_rot2;
    logic [NUM_CH-1:0]     cand_rot;
    logic [IW:0]           win_sum;

    // Highest priority carried by any active requester.
    always_comb begin
        max_pri = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && (pri[i] > max_pri)) begin
                max_pri = pri[i];
            end
        end
    end

    // Candidates: requesters that tie at the maximum priority.
    always_comb begin
        cand = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand[i] = req[i] && (pri[i] == max_pri);
        end
    end

    // Rotate candidates so bit 0 corresponds to the channel at ptr; the
    // doubled vector makes the wrap free for any NUM_CH.
    always_comb begin
        cand_rot2 = {cand, cand} >> ptr;
        cand_rot  = cand_rot2[NUM_CH-1:0];
    end

    // Lowest set bit of the rotated vector, mapped back to a channel index.
    always_comb begin
        win_sum = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand_rot[k]) begin
                win_sum = {1'b0, ptr} + (IW+1)'(k);
            end
        end
        any = |cand_rot;
        if (win_sum >= (IW+1)'(NUM_CH)) begin
            winner = IW'(win_sum - (IW+1)'(NUM_CH));
        end else begin
            winner = win_sum[IW-1:0];
        end
        gnt = any ? (NUM_CH'(1) << winner) : '0;
    end

endmodule

// File: rtl/mem_arb_ctrl.sv
// N-channel arbitrated register-array memory: one write and one read per cycle,
// each port arbitrated independently, byte-strobed writes, 1- or 2-cycle reads
// and a selectable same-address write/read collision policy.
//
// Handshake: a channel raises en with its address/data/priority; the picker
// answers with a combinational ready (one-hot or zero). A transfer happens in
// any cycle where en[i] && ready[i]. Requesters must not make en depend on
// ready. A read transfer returns its data on rdata with a one-cycle rvalid[i]
// pulse exactly RD_LAT cycles later.
module mem_arb_ctrl
    import mem_arb_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int MEM_DEPTH = 32,
    parameter int DATA_W    = 32,
    parameter int RD_LAT    = 1,
    parameter int WR_FIRST  = 1
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_CH-1:0]                          ren,
    input  logic [NUM_CH-1:0][$clog2(MEM_DEPTH)-1:0]   raddr,
    input  pri_t [NUM_CH-1:0]                          rpri,
    output logic [NUM_CH-1:0]                          rready,
    output logic [NUM_CH-1:0]                          rvalid,
    output logic [DATA_W-1:0]                          rdata,
    input  logic [NUM_CH-1:0]                          wen,
    input  logic [NUM_CH-1:0][$clog2(MEM_DEPTH)-1:0]   waddr,
    input  logic [NUM_CH-1:0][DATA_W-1:0]              wdata,
    input  logic [NUM_CH-1:0][DATA_W/8-1:0]            wstrb,
    input  pri_t [NUM_CH-1:0]                          wpri,
    output logic [NUM_CH-1:0]                          wready
);

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int SW  = DATA_W / 8;
    localparam int IW  = $clog2(NUM_CH);
    localparam int LAT = clamp_rd_lat(RD_LAT);

    // Arbitration state and results
    logic [IW-1:0]      rptr_q;
    logic [IW-1:0]      wptr_q;
    logic [NUM_CH-1:0]  rgnt;
    logic [NUM_CH-1:0]  wgnt;
    logic [IW-1:0]      rwin;
    logic [IW-1:0]      wwin;
    logic               rany;
    logic               wany;
    logic               rd_hs;
    logic               wr_hs;

    // Datapath
    logic [DATA_W-1:0]  mem [MEM_DEPTH];
    logic [AW-1:0]      rd_addr;
    logic [AW-1:0]      wr_addr;
    logic [DATA_W-1:0]  wr_data;
    logic [SW-1:0]      wr_strb;
    logic [DATA_W-1:0]  wr_word;
    logic [DATA_W-1:0]  rd_word;
    logic               collide;

    // Read output registers (driven by whichever pipeline depth is built)
    logic [NUM_CH-1:0]  vld_q;
    logic [DATA_W-1:0]  rdata_q;

    mem_arb_rr_pick #(.NUM_CH(NUM_CH)) u_rd_pick (
        .req    (ren),
        .pri    (rpri),
        .ptr    (rptr_q),
        .gnt    (rgnt),
        .winner (rwin),
        .any    (rany)
    );

    mem_arb_rr_pick #(.NUM_CH(NUM_CH)) u_wr_pick (
        .req    (wen),
        .pri    (wpri),
        .ptr    (wptr_q),
        .gnt    (wgnt),
        .winner (wwin),
        .any    (wany)
    );

    // Grants are suppressed while in reset so nothing transfers then.
    assign rready = rgnt & {NUM_CH{rst_n}};
    assign wready = wgnt & {NUM_CH{rst_n}};
    assign rd_hs  = rany & rst_n;
    assign wr_hs  = wany & rst_n;

    // Winning channel's request fields.
    always_comb begin
        rd_addr = raddr[rwin];
        wr_addr = waddr[wwin];
        wr_data = wdata[wwin];
        wr_strb = wstrb[wwin];
    end

    // Strobe merge: the word as it will look after this cycle's write.
    always_comb begin
        wr_word = mem[wr_addr];
        for (int b = 0; b < SW; b++) begin
            if (wr_strb[b]) begin
                wr_word[b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Collision mux: with WR_FIRST a same-address read sees the merged word.
    always_comb begin
        collide = rd_hs && wr_hs && (rd_addr == wr_addr);
        rd_word = ((WR_FIRST != 0) && collide) ? wr_word : mem[rd_addr];
    end

    // Round-robin pointers advance past the winner on each handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rptr_q <= '0;
            wptr_q <= '0;
        end else begin
            if (rd_hs) begin
                rptr_q <= (rwin == IW'(NUM_CH - 1)) ? '0 : rwin + 1'b1;
            end
            if (wr_hs) begin
                wptr_q <= (wwin == IW'(NUM_CH - 1)) ? '0 : wwin + 1'b1;
            end
        end
    end

    // Array write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_hs) begin
            mem[wr_addr] <= wr_word;
        end
    end

    if (LAT == 1) begin : g_lat1
        // Single stage: sampled word and grant land directly on the outputs.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                vld_q   <= '0;
                rdata_q <= '0;
            end else begin
                vld_q <= rd_hs ? rgnt : '0;
                if (rd_hs) begin
                    rdata_q <= rd_word;
                end
            end
        end
    end else begin : g_lat2
        logic [NUM_CH-1:0] s1_vld;
        logic [DATA_W-1:0] s1_data;

        // Two stages: an internal hold register, then the output register.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1_vld  <= '0;
                s1_data <= '0;
                vld_q   <= '0;
                rdata_q <= '0;
            end else begin
                s1_vld <= rd_hs ? rgnt : '0;
                if (rd_hs) begin
                    s1_data <= rd_word;
                end
                vld_q <= s1_vld;
                if (|s1_vld) begin
                    rdata_q <= s1_data;
                end
            end
        end
    end

    // A read caught in the pipe when reset hits is never reported.
    assign rvalid = vld_q & {NUM_CH{rst_n}};
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_mem_arb_ctrl.sv
// Bench for mem_arb_ctrl: two instances share one stimulus stream, one with
// RD_LAT=1/WR_FIRST=1 (a) and one with RD_LAT=2/WR_FIRST=0 (b). A queue model
// predicts grants, rvalid and rdata every cycle; directed literals pin it.
module tb_mem_arb_ctrl;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int SW = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]          ren, wen;
    logic [N-1:0][AW-1:0]  raddr, waddr;
    logic [N-1:0][1:0]     rpri, wpri;
    logic [N-1:0][DW-1:0]  wdata;
    logic [N-1:0][SW-1:0]  wstrb;

    logic [N-1:0]  rready_a, rvalid_a, wready_a;
    logic [N-1:0]  rready_b, rvalid_b, wready_b;
    logic [DW-1:0] rdata_a, rdata_b;

    int errs   = 0;
    int checks = 0;

    mem_arb_ctrl #(.NUM_CH(N), .MEM_DEPTH(32), .DATA_W(DW), .RD_LAT(1), .WR_FIRST(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .ren(ren), .raddr(raddr), .rpri(rpri), .rready(rready_a), .rvalid(rvalid_a), .rdata(rdata_a),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wpri(wpri), .wready(wready_a)
    );

    mem_arb_ctrl #(.NUM_CH(N), .MEM_DEPTH(32), .DATA_W(DW), .RD_LAT(2), .WR_FIRST(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .ren(ren), .raddr(raddr), .rpri(rpri), .rready(rready_b), .rvalid(rvalid_b), .rdata(rdata_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .wpri(wpri), .wready(wready_b)
    );

    task automatic check4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [32];
    int            m_rptr = 0;
    int            m_wptr = 0;
    int            cyc    = 0;
    logic [DW-1:0] exp_q_a[$];
    logic [DW-1:0] exp_q_b[$];
    int            due_a[$], due_b[$], ch_a[$], ch_b[$];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;

    // Highest priority wins; ties go to the channel closest at/after ptr.
    function automatic int pick(input logic [N-1:0] req, input logic [N-1:0][1:0] pri, input int ptr);
        int maxp  = -1;
        int best  = -1;
        int bestd = N;
        for (int i = 0; i < N; i++) begin
            if (req[i] && int'(pri[i]) > maxp) maxp = int'(pri[i]);
        end
        for (int i = 0; i < N; i++) begin
            if (req[i] && int'(pri[i]) == maxp) begin
                int d;
                d = (i - ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [N-1:0] oh(input int w);
        logic [N-1:0] v;
        v = '0;
        if (w >= 0) v[w[1:0]] = 1'b1;
        return v;
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] n, input logic [SW-1:0] s);
        logic [DW-1:0] r;
        r = o;
        for (int b = 0; b < SW; b++) begin
            if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
        end
        return r;
    endfunction

    int            m_rw, m_ww, m_c;
    logic [1:0]    m_rwi, m_wwi;
    logic [N-1:0]  ev_a, ev_b;
    logic [DW-1:0] m_old, m_new, m_d;

    // Scoreboard: compare on the falling edge, then advance the model one cycle.
    always @(negedge clk) begin
        m_rw  = rst_n ? pick(ren, rpri, m_rptr) : -1;
        m_ww  = rst_n ? pick(wen, wpri, m_wptr) : -1;
        m_rwi = m_rw[1:0];
        m_wwi = m_ww[1:0];
        check4("rready_a", rready_a, oh(m_rw));
        check4("rready_b", rready_b, oh(m_rw));
        check4("wready_a", wready_a, oh(m_ww));
        check4("wready_b", wready_b, oh(m_ww));

        ev_a = '0;
        if (due_a.size() > 0 && due_a[0] == cyc) begin
            m_d = exp_q_a.pop_front();
            m_c = ch_a.pop_front();
            void'(due_a.pop_front());
            if (rst_n) begin
                ev_a   = oh(m_c);
                last_a = m_d;
            end
        end
        ev_b = '0;
        if (due_b.size() > 0 && due_b[0] == cyc) begin
            m_d = exp_q_b.pop_front();
            m_c = ch_b.pop_front();
            void'(due_b.pop_front());
            if (rst_n) begin
                ev_b   = oh(m_c);
                last_b = m_d;
            end
        end
        check4("rvalid_a", rvalid_a, ev_a);
        check4("rvalid_b", rvalid_b, ev_b);
        if (rst_n) begin
            check32("rdata_a", rdata_a, last_a);
            check32("rdata_b", rdata_b, last_b);
        end

        if (!rst_n) begin
            exp_q_a.delete(); due_a.delete(); ch_a.delete();
            exp_q_b.delete(); due_b.delete(); ch_b.delete();
            last_a = '0;
            last_b = '0;
            m_rptr = 0;
            m_wptr = 0;
        end else begin
            m_new = '0;
            if (m_ww >= 0) m_new = merge(m_mem[waddr[m_wwi]], wdata[m_wwi], wstrb[m_wwi]);
            if (m_rw >= 0) begin
                m_old = m_mem[raddr[m_rwi]];
                exp_q_a.push_back((m_ww >= 0 && waddr[m_wwi] == raddr[m_rwi]) ? m_new : m_old);
                due_a.push_back(cyc + 1);
                ch_a.push_back(m_rw);
                exp_q_b.push_back(m_old);
                due_b.push_back(cyc + 2);
                ch_b.push_back(m_rw);
                m_rptr = (m_rw + 1) % N;
            end
            if (m_ww >= 0) begin
                m_mem[waddr[m_wwi]] = m_new;
                m_wptr = (m_ww + 1) % N;
            end
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ren   = '0;
        wen   = '0;
        wstrb = '0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
        wen[ch]   = 1'b1;
        waddr[ch] = a;
        wdata[ch] = d;
        wstrb[ch] = s;
    endtask

    task automatic rd(input logic [1:0] ch, input logic [AW-1:0] a);
        ren[ch]   = 1'b1;
        raddr[ch] = a;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1'b0;
        ren   = '1;
        wen   = '1;
        raddr = '0;
        waddr = '0;
        wdata = '0;
        wstrb = '0;
        rpri  = '0;
        wpri  = '0;

        // Reset held three edges with everyone requesting.
        repeat (3) begin
            step();
            check4("rst_rready", rready_a, 4'b0000);
            check4("rst_wready", wready_b, 4'b0000);
            check4("rst_rvalid", rvalid_b, 4'b0000);
        end
        rst_n = 1'b1;
        #1;
        check4("first_rgrant", rready_a, 4'b0001);
        check4("first_wgrant", wready_b, 4'b0001);
        step();
        idle();

        // Preload words used later.
        wr(0, 5'd7, 32'h1122_3344, 4'hF); step(); idle();
        for (int i = 0; i < N; i++) begin
            wr(2'(i), 5'(10 + i), 32'hA0A0_0010 + 32'(i), 4'hF); step(); idle();
        end
        wr(1, 5'd1, 32'h0000_0101, 4'hF); step(); idle();
        wr(2, 5'd2, 32'h0000_0202, 4'hF); step(); idle();

        // Basic write then read on ch1.
        wr(1, 5'd5, 32'hDEAD_BEEF, 4'hF); step(); idle();
        rd(1, 5'd5); step(); idle(); #1;
        check4("basic_rvalid_a", rvalid_a, 4'b0010);
        check32("basic_rdata_a", rdata_a, 32'hDEAD_BEEF);
        check4("basic_rvalid_b_early", rvalid_b, 4'b0000);
        step();
        check4("basic_rvalid_b", rvalid_b, 4'b0010);
        check32("basic_rdata_b", rdata_b, 32'hDEAD_BEEF);
        check4("basic_rvalid_a_pulse", rvalid_a, 4'b0000);

        // Zero-strobe write leaves the word untouched.
        wr(3, 5'd5, 32'h0, 4'h0); #1;
        check4("nostrb_wgrant", wready_a, 4'b1000);
        step(); idle();
        rd(2, 5'd5); step(); idle(); step();
        check32("nostrb_rdata_a", rdata_a, 32'hDEAD_BEEF);
        check32("nostrb_rdata_b", rdata_b, 32'hDEAD_BEEF);

        // Read priority: ch2 (3) beats ch0 (1); ch0 follows once ch2 drops.
        rpri[0] = 2'd1;
        rpri[2] = 2'd3;
        rd(0, 5'd1);
        rd(2, 5'd2); #1;
        check4("pri_rgrant_a", rready_a, 4'b0100);
        check4("pri_rgrant_b", rready_b, 4'b0100);
        step();
        ren[2] = 1'b0; #1;
        check4("pri_followup", rready_a, 4'b0001);
        step(); idle();
        rpri = '0;

        // Write priority: ch3 (2) beats ch0 (0) even though ptr favours ch0 side.
        wpri[3] = 2'd2;
        wr(0, 5'd20, 32'h0000_AAAA, 4'hF);
        wr(3, 5'd20, 32'h0000_BBBB, 4'hF); #1;
        check4("wpri_grant", wready_a, 4'b1000);
        step(); idle();
        wpri = '0;
        rd(0, 5'd20); step(); idle(); #1;
        check32("wpri_rdata_a", rdata_a, 32'h0000_BBBB);

        // Single ch3 read parks the read pointer back at ch0.
        rd(3, 5'd13); step(); idle(); step();

        // Round-robin streaming at equal priority.
        rpri = {N{2'd2}};
        for (int i = 0; i < N; i++) rd(2'(i), 5'(10 + i));
        for (int k = 0; k < 5; k++) begin
            #1;
            check4("rr_grant", rready_a, 4'(1 << (k % N)));
            if (k > 0) begin
                check4("rr_rvalid", rvalid_a, 4'(1 << ((k - 1) % N)));
                check32("rr_rdata", rdata_a, 32'hA0A0_0010 + 32'((k - 1) % N));
            end
            step();
        end
        idle();
        rpri = '0;
        step(); step(); step();

        // Same-address collision on addr 7.
        wr(0, 5'd7, 32'hAABB_CCDD, 4'b0011);
        rd(1, 5'd7); step(); idle(); #1;
        check32("coll_rdata_a", rdata_a, 32'h1122_CCDD);
        step();
        check32("coll_rdata_b", rdata_b, 32'h1122_3344);
        rd(2, 5'd7); step(); idle(); #1;
        check32("coll_after_a", rdata_a, 32'h1122_CCDD);
        step();
        check32("coll_after_b", rdata_b, 32'h1122_CCDD);
        step();

        // Reset while a read is in flight: its rvalid never appears.
        rd(2, 5'd10); step(); idle();
        rst_n = 1'b0; #1;
        check4("rstmid_rvalid_a0", rvalid_a, 4'b0000);
        check4("rstmid_rvalid_b0", rvalid_b, 4'b0000);
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check4("rstmid_rvalid_a", rvalid_a, 4'b0000);
            check4("rstmid_rvalid_b", rvalid_b, 4'b0000);
            step();
        end
        rd(1, 5'd5); step(); idle(); #1;
        check4("post_rst_rvalid_a", rvalid_a, 4'b0010);
        check32("post_rst_rdata_a", rdata_a, 32'hDEAD_BEEF);
        step();
        check32("post_rst_rdata_b", rdata_b, 32'hDEAD_BEEF);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
